regfile_rd_arbiter: RTL and testbench
=====================================

Name: regfile_rd_arbiter

Overview:
- Shares the single register-file read port (32-entry x 64-bit read mux, combinational, 5-bit address in, 64-bit data out) between NUM_REQ requesters: decode operand fetch, store-data fetch, debug read.
- Round-robin arbitration, valid/ready request handshake, registered response with backpressure.
- Sits between the requesters and the read mux; owns the mux address.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 5, register address width
- DATA_W, 64, register data width

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ x ADDR_W  per-requester register address
- req_ready  out  NUM_REQ  one-hot grant; handshake when valid & ready
- mux_addr  out  ADDR_W  address driven to the read mux
- mux_data  in  DATA_W  read mux output (combinational from mux_addr)
- rsp_valid  out  1  response holding data
- rsp_ready  in  1  response consumer accepts
- rsp_data  out  DATA_W  read data
- rsp_id  out  $clog2(NUM_REQ)  index of the requester owning rsp_data
- wr_en  in  1  register-file write strobe, same cycle as the write
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data

Behaviour:
- Interface fixed: one clock, clk; reset_n asynchronous, active-low.
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, mux_addr=0, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- FSM has 3 states:
  - IDLE: if any req_valid, grant the RR winner. Search starts at rr_ptr+1 and wraps modulo NUM_REQ. req_ready is combinational, one-hot, and only asserted in the grant cycle. On the grant, latch addr_q and id_q, set rr_ptr=winner, and go to READ. With no valid request, stay in IDLE.
  - READ: mux_addr=addr_q. Capture mux_data into rsp_data and id_q into rsp_id. Go to RESP.
  - RESP: rsp_valid=1. rsp_data and rsp_id are held stable until rsp_ready.
    - On rsp_ready with a request pending: grant in the same cycle, go to READ.
    - On rsp_ready with nothing pending: go to IDLE.
    - Without rsp_ready: no grants.
- mux_addr holds addr_q outside READ (no toggling).
- Latency: grant cycle N, rsp_valid at cycle N+2. Sustained throughput is 1 read per 2 cycles.
- Requesters must hold req_addr stable while req_valid is high and not yet granted. Dropping req_valid before a grant is legal; the request is simply lost.
- Only one request is outstanding at a time; req_ready is never asserted while rsp_valid is high and rsp_ready is low.
- Single requester: repeated grants to the same index are allowed.
- Address 31 is read like any other (mux returns its contents).
- Reset asserted mid-operation: immediately return to reset values. The in-flight read and any pending response are discarded.

Optional Feature:
- Macro: REGFILE_RD_BYPASS_EN.
- Defined: in READ, if wr_en and wr_addr==addr_q and wr_addr!=31, capture wr_data instead of mux_data (write-to-read forwarding; X31 is never forwarded).
- Undefined: wr_en, wr_addr and wr_data are ignored; rsp_data is always captured from mux_data.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=64, XZR_IDX=5'd31
  - state enum typedef rd_arb_state_t {IDLE, READ, RESP}
- One sub-module: rr_arbiter. Inputs are req vector and rr_ptr; outputs are one-hot grant and encoded index. It is purely combinational, parameterised by NUM_REQ.

Test Plan:
- Reset: reset_n=0 mid-READ -> rsp_valid=0, req_ready=0, mux_addr=0 immediately; after release, req0 is granted before req1 when both are valid.
- Single read: mux model reg[7]=64'hDEAD_BEEF_0000_0007, req2 valid addr=7, rsp_ready=1 -> req_ready[2] at cycle N, mux_addr=7 at N+1, rsp_valid at N+2 with rsp_data=64'hDEAD_BEEF_0000_0007, rsp_id=2.
- Round robin: all 4 requesters held valid with addrs 1,2,3,4 -> rsp_id sequence 0,1,2,3,0 with data reg[1..4], reg[1]; exactly one grant every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles with req1 pending -> rsp_data and rsp_id stable, req_ready=0; rsp_ready=1 -> req1 granted in the same cycle.
- Wrap-around: rr_ptr=3, only req3 and req0 valid -> req0 granted first, then req3.
- Bypass (REGFILE_RD_BYPASS_EN): reg[5]=1, wr_en with wr_addr=5, wr_data=64'h55 during READ of addr 5 -> rsp_data=64'h55. Same with addr 31 -> mux value. Without the macro -> rsp_data=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the read-arbiter state encoding.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;
  localparam logic [REG_ADDR_W-1:0] XZR_IDX = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } rd_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past rr_ptr and
// wraps modulo NUM_REQ.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  int cand;

  // NOTE: every output gets a default before the loop, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i) % NUM_REQ;
      if (!grant_any && req[IDX_W'(cand)]) begin
        grant_any                = 1'b1;
        grant[IDX_W'(cand)]      = 1'b1;
        grant_idx                = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_rd_arbiter.sv
// Round-robin owner of the register-file read port with a registered response.
// Optional write-to-read forwarding is enabled by defining REGFILE_RD_BYPASS_EN.
module regfile_rd_arbiter
  import regfile_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_W  = REG_ADDR_W,
  parameter  int DATA_W  = REG_DATA_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ADDR_W-1:0]              mux_addr,
  input  logic [DATA_W-1:0]              mux_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_W-1:0]              rsp_data,
  output logic [IDX_W-1:0]               rsp_id,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data
);

  rd_arb_state_t state_q, state_d;

  logic [ADDR_W-1:0]  addr_q;
  logic [IDX_W-1:0]   id_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               grant_en;
  logic               do_grant;
  logic [DATA_W-1:0]  capture_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_en = 1'b1;
        if (arb_any) state_d = READ;
      end
      READ: state_d = RESP;
      RESP: begin
        // A new grant may only overlap the cycle the old response is taken.
        if (rsp_ready) begin
          grant_en = 1'b1;
          state_d  = arb_any ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with reset_n keeps req_ready low while reset is held even though
  // the state register already reads IDLE.
  assign do_grant  = reset_n && grant_en && arb_any;
  assign req_ready = do_grant ? arb_grant : '0;
  assign rsp_valid = (state_q == RESP);
  assign mux_addr  = addr_q;

`ifdef REGFILE_RD_BYPASS_EN
  // X31 is the zero register, so a write to it must never be forwarded.
  assign capture_data = (wr_en && (wr_addr == addr_q) && (wr_addr != ADDR_W'(XZR_IDX)))
                        ? wr_data : mux_data;
`else
  logic unused_wr;
  assign unused_wr    = ^{wr_en, wr_addr, wr_data};
  assign capture_data = mux_data;
`endif

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; the data registers are reset too because their reset
  // values are architecturally visible on rsp_data/rsp_id/mux_addr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      id_q     <= '0;
      rr_ptr   <= IDX_W'(NUM_REQ - 1);
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state_q <= state_d;
      if (do_grant) begin
        addr_q <= req_addr[arb_idx];
        id_q   <= arb_idx;
        rr_ptr <= arb_idx;
      end
      if (state_q == READ) begin
        rsp_data <= capture_data;
        rsp_id   <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_regfile_rd_arbiter.sv
// Self-checking bench for regfile_rd_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_regfile_rd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 64;
  localparam int IDX_W   = 2;
`ifdef REGFILE_RD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                           clk = 1'b0;
  logic                           reset_n = 1'b0;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]             req_ready;
  logic [ADDR_W-1:0]              mux_addr;
  logic [DATA_W-1:0]              mux_data;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [DATA_W-1:0]              rsp_data;
  logic [IDX_W-1:0]               rsp_id;
  logic                           wr_en;
  logic [ADDR_W-1:0]              wr_addr;
  logic [DATA_W-1:0]              wr_data;

  logic [DATA_W-1:0] regs [32];
  int n_vec = 0;
  int n_err = 0;

  regfile_rd_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .mux_addr  (mux_addr),
    .mux_data  (mux_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  // Register-file model: combinational read, write at the clock edge.
  assign mux_data = regs[mux_addr];
  always @(posedge clk) if (wr_en) regs[wr_addr] <= wr_data;

  task automatic do_reset();
    req_valid = '0; req_addr = '0; rsp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 4'b0011; req_addr = '0; req_addr[0] = 5'd3; req_addr[1] = 5'd4;
    rsp_ready = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    @(posedge clk); @(negedge clk);
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (mux_addr !== 5'd0) begin n_err++; $display("FAIL reset_mux_addr: got %0d want 0", mux_addr); end
    n_vec++; if (rsp_data !== 64'd0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
    @(posedge clk); #1;
    n_vec++; if (mux_addr !== 5'd3) begin n_err++; $display("FAIL reset_read_addr: got %0d want 3", mux_addr); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL midread_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL midread_req_ready: got %b want 0000", req_ready); end
    n_vec++; if (mux_addr !== 5'd0) begin n_err++; $display("FAIL midread_mux_addr: got %0d want 0", mux_addr); end
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rereset_grant: got %b want 0001", req_ready); end
    @(posedge clk); @(negedge clk);
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rereset_read_ready: got %b want 0000", req_ready); end
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rereset_second_grant: got %b want 0010", req_ready); end
    n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL rereset_rsp_id: got %0d want 0", rsp_id); end
    n_vec++; if (rsp_data !== regs[3]) begin n_err++; $display("FAIL rereset_rsp_data: got %h want %h", rsp_data, regs[3]); end
    @(posedge clk); #1 req_valid = '0;
  endtask

  task automatic test_single_read();
    do_reset();
    regs[7] = 64'hDEAD_BEEF_0000_0007;
    req_valid = 4'b0100; req_addr[2] = 5'd7; rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_vec++; if (mux_addr !== 5'd7) begin n_err++; $display("FAIL single_mux_addr: got %0d want 7", mux_addr); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    n_vec++; if (rsp_data !== 64'hDEAD_BEEF_0000_0007) begin n_err++; $display("FAIL single_rsp_data: got %h want deadbeef00000007", rsp_data); end
    n_vec++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL single_rsp_id: got %0d want 2", rsp_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) req_addr[i] = ADDR_W'(i + 1);
    for (int cy = 0; cy <= 10; cy++) begin
      @(negedge clk);
      if (cy % 2 == 0) begin
        int k = cy / 2;
        logic [3:0] exp_rdy = 4'(1 << (k % 4));
        n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready, exp_rdy); end
        if (k >= 1) begin
          int p = (k - 1) % 4;
          n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rr_rsp_valid_%0d: got %b want 1", k, rsp_valid); end
          n_vec++; if (rsp_id !== IDX_W'(p)) begin n_err++; $display("FAIL rr_rsp_id_%0d: got %0d want %0d", k, rsp_id, p); end
          n_vec++; if (rsp_data !== regs[p + 1]) begin n_err++; $display("FAIL rr_rsp_data_%0d: got %h want %h", k, rsp_data, regs[p + 1]); end
        end
      end else begin
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rr_gap_%0d: got %b want 0000", cy, req_ready); end
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0001; req_addr[0] = 5'd10; rsp_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_first_grant: got %b want 0001", req_ready); end
    @(posedge clk); #1 req_valid = 4'b0010; req_addr[1] = 5'd11;
    @(posedge clk); #1;
    for (int cy = 0; cy < 5; cy++) begin
      @(negedge clk);
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_%0d: got %b want 1", cy, rsp_valid); end
      n_vec++; if (rsp_data !== regs[10]) begin n_err++; $display("FAIL bp_data_%0d: got %h want %h", cy, rsp_data, regs[10]); end
      n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL bp_id_%0d: got %0d want 0", cy, rsp_id); end
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready_%0d: got %b want 0000", cy, req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_grant: got %b want 0010", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_read_valid: got %b want 0", rsp_valid); end
    @(negedge clk);
    n_vec++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL bp_second_id: got %0d want 1", rsp_id); end
    n_vec++; if (rsp_data !== regs[11]) begin n_err++; $display("FAIL bp_second_data: got %h want %h", rsp_data, regs[11]); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_around();
    logic [3:0] exp_seq [3];
    int         exp_id  [3];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b1000; exp_seq[2] = 4'b0001;
    exp_id[0] = 0; exp_id[1] = 3; exp_id[2] = 0;
    do_reset();
    req_valid = 4'b1001; req_addr[0] = 5'd20; req_addr[3] = 5'd21; rsp_ready = 1'b1;
    for (int cy = 0; cy <= 4; cy++) begin
      @(negedge clk);
      if (cy % 2 == 0) begin
        n_vec++; if (req_ready !== exp_seq[cy / 2]) begin n_err++; $display("FAIL wrap_grant_%0d: got %b want %b", cy / 2, req_ready, exp_seq[cy / 2]); end
        if (cy >= 2) begin
          int p = exp_id[cy / 2 - 1];
          n_vec++; if (rsp_id !== IDX_W'(p)) begin n_err++; $display("FAIL wrap_rsp_id_%0d: got %0d want %0d", cy / 2, rsp_id, p); end
          n_vec++; if (rsp_data !== regs[p == 0 ? 20 : 21]) begin n_err++; $display("FAIL wrap_rsp_data_%0d: got %h", cy / 2, rsp_data); end
        end
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] old31;
    logic [DATA_W-1:0] exp5;
    do_reset();
    regs[5] = 64'd1;
    req_valid = 4'b0001; req_addr[0] = 5'd5; rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL byp_grant5: got %b want 0001", req_ready); end
    @(posedge clk); #1 req_valid = '0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h55;
    @(posedge clk); #1 wr_en = 1'b0;
    @(negedge clk);
    exp5 = BYPASS ? 64'h55 : 64'd1;
    n_vec++; if (rsp_data !== exp5) begin n_err++; $display("FAIL byp_addr5: got %h want %h", rsp_data, exp5); end
    @(posedge clk); #1;
    old31 = regs[31];
    req_valid = 4'b0001; req_addr[0] = 5'd31;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL byp_grant31: got %b want 0001", req_ready); end
    @(posedge clk); #1 req_valid = '0; wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h77;
    @(posedge clk); #1 wr_en = 1'b0;
    @(negedge clk);
    n_vec++; if (rsp_data !== old31) begin n_err++; $display("FAIL byp_addr31: got %h want %h", rsp_data, old31); end
    @(posedge clk); #1;
  endtask

  // Transaction-level model: a grant at cycle N reads at N+1 and presents the
  // response from N+2 until it is accepted; grants only when nothing is owed.
  task automatic test_random(int n_cycles);
    bit                busy = 1'b0;
    int                g_cyc = 0;
    int                g_id = 0;
    logic [ADDR_W-1:0] g_addr = '0;
    logic [DATA_W-1:0] g_data = '0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [3:0]        pend = '0;
    logic [3:0]        exp_rdy;
    int                last = NUM_REQ - 1;
    int                win;
    bit                exp_rv, allowed, rr_s;
    do_reset();
    for (int cy = 0; cy < n_cycles; cy++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pend[i]) req_valid[i] = ($urandom_range(0, 7) != 0);
        else begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_addr[i]  = ADDR_W'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = ADDR_W'($urandom);
      wr_data   = {$urandom, $urandom};
      if (busy && cy == g_cyc + 1 && $urandom_range(0, 1) == 1) wr_addr = g_addr;
      @(negedge clk);
      exp_rv = busy && (cy >= g_cyc + 2);
      if (busy && cy == g_cyc + 1)
        g_data = (BYPASS && wr_en && wr_addr == g_addr && g_addr != 5'd31) ? wr_data : regs[g_addr];
      rr_s    = rsp_ready;
      allowed = !busy || (exp_rv && rr_s);
      win     = -1;
      if (allowed)
        for (int k = 1; k <= NUM_REQ; k++)
          if (win < 0 && req_valid[(last + k) % NUM_REQ]) win = (last + k) % NUM_REQ;
      exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0000;
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rand_ready cy%0d: got %b want %b", cy, req_ready, exp_rdy); end
      n_vec++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL rand_valid cy%0d: got %b want %b", cy, rsp_valid, exp_rv); end
      n_vec++; if (mux_addr !== m_addr) begin n_err++; $display("FAIL rand_mux_addr cy%0d: got %0d want %0d", cy, mux_addr, m_addr); end
      if (exp_rv) begin
        n_vec++; if (rsp_data !== g_data) begin n_err++; $display("FAIL rand_data cy%0d: got %h want %h", cy, rsp_data, g_data); end
        n_vec++; if (rsp_id !== IDX_W'(g_id)) begin n_err++; $display("FAIL rand_id cy%0d: got %0d want %0d", cy, rsp_id, g_id); end
      end
      @(posedge clk); #1;
      if (exp_rv && rr_s) busy = 1'b0;
      if (win >= 0) begin
        busy   = 1'b1;
        g_cyc  = cy;
        g_id   = win;
        g_addr = req_addr[win];
        m_addr = req_addr[win];
        last   = win;
      end
      pend = req_valid & ~exp_rdy;
    end
    req_valid = '0; wr_en = 1'b0; rsp_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_wrap_around();
    test_bypass();
    test_random(800);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
